// File: rtl/rr_mux_reg_if.sv
// Handshake bundle for rr_mux_reg: N producer channels in, one registered consumer port out.
// The master modport is the producer/consumer environment; the slave modport is the mux itself.
interface rr_mux_reg_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/rr_mux_reg.sv
// Parametrised N:1 channel mux with fixed or round-robin selection, feeding a single
// registered output stage with valid/ready handshakes on both sides.
module rr_mux_reg #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4
) (
  input logic          clk,
  input logic          rst_n,
  rr_mux_reg_if.slave  bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0] out_chan_q, out_chan_d;
  logic             out_valid_q, out_valid_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             load_en;
  logic             grant_valid;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] grant_data;
  int               idx;

  assign load_en = !out_valid_q || bus.out_ready;

  // Grant selection. Every index is compared against loop constants, so channel numbers
  // at or above CHANNELS can never be granted.
  // NOTE: every variable assigned in always_comb gets a default first; a path that skips an
  // assignment would otherwise infer a latch.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    if (mode_e'(bus.mode) == MODE_FIXED) begin
      for (int j = 0; j < CHANNELS; j++) begin
        if ((CHANNELS == 1 || int'(bus.sel) == j) && bus.in_valid[j]) begin
          grant_valid = 1'b1;
          grant_idx   = SEL_W'(j);
        end
      end
    end else begin
      // Search starts just after the last granted channel and wraps at CHANNELS-1.
      for (int k = 1; k <= CHANNELS; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        for (int j = 0; j < CHANNELS; j++) begin
          if (!grant_valid && j == idx && bus.in_valid[j]) begin
            grant_valid = 1'b1;
            grant_idx   = SEL_W'(j);
          end
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      if (grant_idx == SEL_W'(j)) grant_data = bus.in_data[j*WIDTH +: WIDTH];
    end
  end

  // in_ready is gated by rst_n so that no producer sees an accept while reset is asserted.
  always_comb begin
    bus.in_ready = '0;
    for (int j = 0; j < CHANNELS; j++) begin
      bus.in_ready[j] = rst_n && load_en && grant_valid && (grant_idx == SEL_W'(j));
    end
  end

  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (load_en) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = grant_data;
        out_chan_d = grant_idx;
        ptr_d      = grant_idx;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so all registers update from the same
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_rr_mux_reg.sv
// Directed bench for rr_mux_reg: a 4-channel instance for the main behaviour and a
// 3-channel instance for the non-power-of-two boundary.
module tb_rr_mux_reg;
  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;

  rr_mux_reg_if #(.WIDTH(8), .CHANNELS(4)) a ();
  rr_mux_reg_if #(.WIDTH(8), .CHANNELS(3)) b ();

  rr_mux_reg #(.WIDTH(8), .CHANNELS(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  rr_mux_reg #(.WIDTH(8), .CHANNELS(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out4(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
    check({tag, ".valid"}, 32'(a.out_valid), 32'(v));
    check({tag, ".data"},  32'(a.out_data),  32'(d));
    check({tag, ".chan"},  32'(a.out_chan),  32'(c));
  endtask

  logic [7:0] rr_data [4];
  logic [1:0] exp_fair [8];
  logic [1:0] exp_skip [4];
  logic [7:0] b_data [3];
  logic [1:0] exp_b [4];

  initial begin
    n_total  = 0;
    n_pass   = 0;
    rr_data  = '{8'h10, 8'h21, 8'h32, 8'h43};
    exp_fair = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3};
    exp_skip = '{2'd1, 2'd3, 2'd1, 2'd3};
    b_data   = '{8'hA0, 8'hB1, 8'hC2};
    exp_b    = '{2'd0, 2'd1, 2'd2, 2'd0};

    rst_n = 1'b0;
    a.in_data = '0; a.in_valid = '0; a.mode = 1'b0; a.sel = '0; a.out_ready = 1'b0;
    b.in_data = '0; b.in_valid = '0; b.mode = 1'b0; b.sel = '0; b.out_ready = 1'b0;
    repeat (2) tick();
    chk_out4("reset", 1'b0, 8'h00, 2'd0);
    check("reset.in_ready", 32'(a.in_ready), 32'h0);
    rst_n = 1'b1;

    // Fixed mode, sel = 2
    a.in_data  = {8'h44, 8'h3C, 8'h22, 8'h11};
    a.in_valid = 4'b1111;
    a.mode     = 1'b0;
    a.sel      = 2'd2;
    a.out_ready = 1'b1;
    #1 check("fixed.in_ready", 32'(a.in_ready), 32'b0100);
    tick();
    chk_out4("fixed.load", 1'b1, 8'h3C, 2'd2);
    a.in_valid = 4'b1011;
    #1 check("fixed.novalid.in_ready", 32'(a.in_ready), 32'h0);
    tick();
    check("fixed.novalid.out_valid", 32'(a.out_valid), 32'h0);

    // Fill with A5 and stall, then reset asynchronously mid-stall
    a.in_data  = {8'h44, 8'h3C, 8'hA5, 8'h11};
    a.in_valid = 4'b0010;
    a.sel      = 2'd1;
    a.out_ready = 1'b0;
    tick();
    chk_out4("stall.load", 1'b1, 8'hA5, 2'd1);
    tick();
    check("stall.hold.data", 32'(a.out_data), 32'hA5);
    check("stall.in_ready", 32'(a.in_ready), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_out4("async_reset", 1'b0, 8'h00, 2'd0);
    check("async_reset.in_ready", 32'(a.in_ready), 32'h0);
    tick();
    rst_n = 1'b1;

    // Round-robin fairness: all valid, ptr starts at 3
    a.in_data  = {rr_data[3], rr_data[2], rr_data[1], rr_data[0]};
    a.in_valid = 4'b1111;
    a.mode     = 1'b1;
    a.out_ready = 1'b1;
    #1 check("rr.first.in_ready", 32'(a.in_ready), 32'b0001);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_out4($sformatf("rr.fair%0d", i), 1'b1, rr_data[exp_fair[i]], exp_fair[i]);
    end

    // Round-robin skip of invalid channels
    a.in_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out4($sformatf("rr.skip%0d", i), 1'b1, rr_data[exp_skip[i]], exp_skip[i]);
    end
    a.in_valid = 4'b0001;
    tick();
    chk_out4("rr.wrap0", 1'b1, 8'h10, 2'd0);

    // Backpressure: mode/sel changes during the stall must not disturb the held word
    a.in_valid = 4'b1111;
    a.out_ready = 1'b0;
    a.mode = 1'b0;
    a.sel  = 2'd3;
    #1 check("bp.in_ready0", 32'(a.in_ready), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out4($sformatf("bp.hold%0d", i), 1'b1, 8'h10, 2'd0);
      check($sformatf("bp.in_ready%0d", i), 32'(a.in_ready), 32'h0);
    end
    a.mode = 1'b1;
    a.out_ready = 1'b1;
    #1 check("bp.release.in_ready", 32'(a.in_ready), 32'b0010);
    tick();
    chk_out4("bp.nobubble", 1'b1, 8'h21, 2'd1);

    a.in_valid = 4'b0000;
    #1 check("rr.none.in_ready", 32'(a.in_ready), 32'h0);
    tick();
    check("rr.none.out_valid", 32'(a.out_valid), 32'h0);

    a.mode = 1'b0;
    a.sel  = 2'd3;
    a.in_valid = 4'b1000;
    #1 check("fixed.sel3.in_ready", 32'(a.in_ready), 32'b1000);
    tick();
    chk_out4("fixed.sel3", 1'b1, 8'h43, 2'd3);

    // Three-channel boundary
    b.in_data  = {b_data[2], b_data[1], b_data[0]};
    b.in_valid = 3'b111;
    b.mode     = 1'b0;
    b.sel      = 2'd3;
    b.out_ready = 1'b1;
    #1 check("c3.sel3.in_ready", 32'(b.in_ready), 32'h0);
    tick();
    check("c3.sel3.out_valid", 32'(b.out_valid), 32'h0);
    b.mode = 1'b1;
    #1 check("c3.rr.in_ready", 32'(b.in_ready), 32'b001);
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("c3.rr%0d.chan", i), 32'(b.out_chan), 32'(exp_b[i]));
      check($sformatf("c3.rr%0d.data", i), 32'(b.out_data), 32'(b_data[exp_b[i]]));
      check($sformatf("c3.rr%0d.valid", i), 32'(b.out_valid), 32'h1);
    end
    b.mode = 1'b0;
    b.sel  = 2'd2;
    #1 check("c3.sel2.in_ready", 32'(b.in_ready), 32'b100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/rr_mux_reg.md
Name: rr_mux_reg

Overview:
- Parametrised successor to the fixed 4:1 bit mux.
- Selects one of CHANNELS WIDTH-bit input channels and holds it in a registered output stage with valid/ready handshakes.
- Two selection modes: fixed (external select code) and round-robin (fair arbitration among valid channels).
- Sits in front of the ALU operand/result path, where several producers share one consumer.

Parameters:
- WIDTH, 8: data bits per channel; WIDTH >= 1.
- CHANNELS, 4: number of input channels; CHANNELS >= 1, power of two not required.
- SEL_W is a derived localparam, not overridable: SEL_W = max(1, clog2(CHANNELS)).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  CHANNELS  per-channel valid.
- in_ready  output  CHANNELS  per-channel ready; combinational, at most one bit high.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SEL_W  channel index; used only when mode = 0.
- out_data  output  WIDTH  registered data.
- out_chan  output  SEL_W  registered index of the source channel.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.

Behaviour:
- Reset (asynchronous, effective immediately): out_valid = 0, out_data = 0, out_chan = 0, ptr = CHANNELS-1. Any held word is discarded; in_ready goes low.
- ptr holds the last granted channel.
- load_en = !out_valid || out_ready.
- Grant when mode = 0:
  - grant = sel if sel < CHANNELS and in_valid[sel] = 1.
  - No grant if sel >= CHANNELS, or if the selected channel is not valid.
- Grant when mode = 1:
  - Search from ptr+1 upward, wrapping CHANNELS-1 -> 0.
  - The first channel with in_valid = 1 is granted; no grant if none are valid.
- in_ready[i] = load_en && grant_valid && (grant_idx == i). All other bits are 0.
- Transfer occurs on in_valid[i] && in_ready[i]. At the next edge:
  - out_valid <= 1, out_data <= channel i data, out_chan <= i, ptr <= i.
  - ptr updates in both modes, so a later switch to round-robin continues fairly.
- Latency: exactly 1 cycle from transfer to out_valid.
- Throughput: one word per cycle. Drain (out_valid && out_ready) and load happen in the same cycle.
- load_en = 1 with no grant: out_valid <= 0. out_data and out_chan keep their values; they are don't-care while out_valid = 0.
- Stall (out_valid && !out_ready):
  - out_data, out_chan and out_valid hold stable.
  - All in_ready = 0.
  - mode and sel changes during a stall do not affect the held word.
- mode and sel are combinational inputs, evaluated each cycle. No handshake is needed to change them.
- An input's in_valid may drop without a transfer. No word is lost, because none was accepted.
- CHANNELS = 1: sel is ignored and grant = channel 0 whenever it is valid; SEL_W = 1 and out_chan is always 0.
- Non-power-of-two CHANNELS: indices >= CHANNELS are never granted or reached by the round-robin search.

Test Plan:
- Reset: assert rst_n = 0 mid-stall with out_valid = 1 and out_data = 8'hA5 -> out_valid = 0, out_data = 0, all in_ready = 0 immediately; after release, the first round-robin grant goes to channel 0.
- Fixed mode: mode = 0, sel = 2, in_valid = 4'b1111, ch2 = 8'h3C, out_ready = 1 -> in_ready = 4'b0100; next cycle out_valid = 1, out_data = 8'h3C, out_chan = 2. Then sel = 2 with in_valid[2] = 0 -> in_ready = 0, out_valid drops after one cycle.
- Round-robin fairness: mode = 1, all four channels valid continuously, out_ready = 1 -> out_chan sequence 0,1,2,3,0,1 on consecutive cycles with out_valid held at 1.
- Round-robin skip: in_valid = 4'b1010 -> grants 1,3,1,3. Then, after ptr = 3, set in_valid = 4'b0001 -> grant 0.
- Backpressure: out_ready = 0 for 3 cycles while out_valid = 1 -> out_data is stable, in_ready = 0, ptr unchanged; raising out_ready loads the next word in the same cycle with no bubble.
- Boundary: CHANNELS = 3 with mode = 0, sel = 3 -> never granted. CHANNELS = 3 with mode = 1 and all channels valid -> sequence 0,1,2,0 (wrap at 2).
